// File: rtl/nibble_packer_if.sv
// ============================================================================
//  Module  : nibble_packer_if
//  Purpose : FIFO read side plus packed-byte output channel of nibble_packer.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface nibble_packer_if;
   logic        rempty;
   logic [3:0]  rdata;
   logic        rinc;
   logic        flush;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_ready;
   logic        partial;
   logic [15:0] byte_cnt;

   // master: the packer itself
   modport master (
      input  rempty, rdata, flush, m_ready,
      output rinc, m_data, m_valid, partial, byte_cnt
   );

   // slave: the FIFO and byte consumer around the packer
   modport slave (
      output rempty, rdata, flush, m_ready,
      input  rinc, m_data, m_valid, partial, byte_cnt
   );
endinterface

`default_nettype wire

// File: rtl/nibble_packer.sv
// ============================================================================
//  Module  : nibble_packer
//  Purpose : Pops nibbles from a FWFT FIFO and packs pairs into bytes.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module nibble_packer #(
   parameter bit LO_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   nibble_packer_if.master  bus
);

   // Encoding is {valid, hold}, so the outputs come straight off the state flops.
   typedef enum logic [1:0] {
      S_IDLE      = 2'b00,
      S_HALF      = 2'b01,
      S_BYTE      = 2'b10,
      S_BYTE_HALF = 2'b11
   } state_t;

   state_t      state_q;
   logic [3:0]  hold_q;
   logic [7:0]  data_q;
   logic [15:0] cnt_q;

   logic        w_pop;
   logic        w_xfer;

   function automatic logic [7:0] pack(input logic [3:0] first, input logic [3:0] second);
      return LO_FIRST ? {second, first} : {first, second};
   endfunction

   always_comb begin
      w_pop  = !rst && !bus.rempty && !bus.flush &&
               !((state_q == S_BYTE_HALF) && !bus.m_ready);
      w_xfer = state_q[1] && bus.m_ready;
   end

   assign bus.rinc     = w_pop;
   assign bus.m_valid  = state_q[1];
   assign bus.partial  = state_q[0];
   assign bus.m_data   = data_q;
   assign bus.byte_cnt = cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         hold_q  <= 4'h0;
         data_q  <= 8'h00;
         cnt_q   <= 16'h0000;
      end else begin
         if (w_xfer) begin
            cnt_q <= cnt_q + 16'd1;
         end
         case (state_q)
            S_IDLE: begin
               if (w_pop) begin
                  hold_q  <= bus.rdata;
                  state_q <= S_HALF;
               end
            end
            S_HALF: begin
               if (w_pop) begin
                  data_q  <= pack(hold_q, bus.rdata);
                  state_q <= S_BYTE;
               end else if (bus.flush) begin
                  data_q  <= pack(hold_q, 4'h0);
                  state_q <= S_BYTE;
               end
            end
            S_BYTE: begin
               if (w_pop) begin
                  hold_q  <= bus.rdata;
                  state_q <= w_xfer ? S_HALF : S_BYTE_HALF;
               end else if (w_xfer) begin
                  state_q <= S_IDLE;
               end
            end
            S_BYTE_HALF: begin
               // Pop is already gated off here unless the current byte leaves.
               if (w_xfer) begin
                  if (w_pop) begin
                     data_q  <= pack(hold_q, bus.rdata);
                     state_q <= S_BYTE;
                  end else if (bus.flush) begin
                     data_q  <= pack(hold_q, 4'h0);
                     state_q <= S_BYTE;
                  end else begin
                     state_q <= S_HALF;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: doc/nibble_packer.md
NIBBLE_PACKER -- requirements
Module: nibble_packer

Interface
REQ-001 SHALL have parameter LO_FIRST, default 1: when 1, the first nibble popped fills m_data[3:0]; when 0, it fills m_data[7:4].
REQ-002 SHALL have port clk, input, 1 bit: the single clock, i.e. the read-side clock of the async FIFO.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port rempty, input, 1 bit: FIFO empty flag.
REQ-005 SHALL have port rdata, input, 4 bits: FIFO head nibble, valid whenever rempty=0 (first-word-fall-through).
REQ-006 SHALL have port rinc, output, 1 bit: FIFO pop; the head is consumed at the clk edge where rinc=1.
REQ-007 SHALL have port flush, input, 1 bit: level request to emit a held odd nibble, zero-padded.
REQ-008 SHALL have port m_data, output, 8 bits: packed byte.
REQ-009 SHALL have port m_valid, output, 1 bit: m_data is valid.
REQ-010 SHALL have port m_ready, input, 1 bit: consumer accepts; a transfer occurs on a clk edge with m_valid and m_ready both high.
REQ-011 SHALL have port partial, output, 1 bit: one nibble is held.
REQ-012 SHALL have port byte_cnt, output, 16 bits: count of completed output transfers.

Function
REQ-013 SHALL use a 4-state FSM, registered:
- IDLE: hold=0, valid=0.
- HALF: hold=1, valid=0.
- BYTE: hold=0, valid=1.
- BYTE_HALF: hold=1, valid=1.
REQ-014 SHALL drive m_valid=1 in BYTE and BYTE_HALF only, and partial=1 in HALF and BYTE_HALF only, both as registered outputs.
REQ-015 SHALL drive rinc combinationally as !rempty && !flush && !(state==BYTE_HALF && !m_ready); call this pop p.
REQ-016 SHALL define r = m_valid && m_ready.
REQ-017 SHALL make these transitions:
- IDLE: p -> HALF (latch nibble); otherwise stay.
- HALF: p -> BYTE (assemble byte); flush -> BYTE (held nibble plus 4'h0); otherwise stay.
- BYTE: r&p -> HALF; r&!p -> IDLE; !r&p -> BYTE_HALF; otherwise stay.
- BYTE_HALF: r&p -> BYTE (new byte from held nibble plus rdata); r&flush -> BYTE (padded byte); r&!p&!flush -> HALF; !r -> stay.
REQ-018 SHALL hold m_data and m_valid stable while m_valid=1 and m_ready=0.
REQ-019 SHALL assemble each byte from the held nibble, placed per LO_FIRST, and the second nibble (or 4'h0 on flush) in the other half.
REQ-020 SHALL ignore flush in IDLE and BYTE, and in BYTE_HALF while m_ready=0, with no side effects except that rinc stays gated per REQ-015.
REQ-021 SHALL produce the first byte with 2-cycle latency from the first pop, i.e. m_valid rises at the edge of the second pop.
REQ-022 SHALL sustain one byte per 2 clk cycles while rempty=0 and m_ready=1, with no bubbles.
REQ-023 SHALL increment byte_cnt by 1 on each r and wrap from 16'hFFFF to 16'h0000.
REQ-024 SHALL not pop when rempty=1, regardless of state.
REQ-025 SHALL never drop a nibble and never duplicate or reorder nibbles or bytes.

Reset
REQ-026 SHALL, on rst=1 at any time including mid-transfer, immediately force state IDLE, m_valid=0, partial=0, m_data=8'h00, byte_cnt=16'h0000, and discard any held nibble.
REQ-027 SHALL hold rinc=0 while rst=1.
REQ-028 SHALL resume normal operation on the first clk edge after rst deasserts.

Verification
REQ-029 SHALL cover back-to-back throughput: LO_FIRST=1, nibbles 4'h3, 4'hA, 4'h5, 4'hC, m_ready=1 -> bytes 8'hA3 then 8'hC5, 2 cycles apart, byte_cnt=2.
REQ-030 SHALL cover backpressure: m_ready=0 with 3 nibbles available -> state BYTE_HALF, rinc=0, m_data stable; m_ready=1 -> transfer, then pop resumes.
REQ-031 SHALL cover flush: LO_FIRST=0, single nibble 4'h9, then flush=1 -> m_data=8'h90, m_valid=1, partial=0.
REQ-032 SHALL cover the empty boundary: rempty toggling every cycle -> rinc never asserted while rempty=1, no lost or duplicated nibbles versus a scoreboard.
REQ-033 SHALL cover reset mid-operation: rst asserted in BYTE_HALF -> all outputs zero asynchronously; the next two nibbles after release form a fresh byte.
REQ-034 SHALL cover counter wrap: byte_cnt preloaded via 65535 transfers, then one more transfer -> byte_cnt=16'h0000.
